// File: rtl/raw_hazard_tracker.sv
// Read-after-write hazard tracker for the instruction in ID.
// A 3-deep shadow pipeline (EX, MEM, WB) holds the destination tags of
// in-flight register writes. The ID sources are compared against every
// entry each cycle. A saturating counter records the hazard cycles.
module raw_hazard_tracker #(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic             id_rs1_re,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_rs2_re,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_rd_we,
  input  logic             stall,
  input  logic             flush,
  output logic             hazard_ID_EXE,
  output logic             hazard_EXE_MEM,
  output logic             hazard_MEM_WB,
  output logic [1:0]       pend_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic            ex_v, mem_v, wb_v;
  logic [RA_W-1:0] ex_rd, mem_rd, wb_rd;
  logic            ex_load_v;
  logic            any_hazard;

  // EX entry load. A held or killed ID slot becomes a bubble; x0 is never tracked.
  always_comb begin
    ex_load_v = 1'b0;
    if (!flush && !stall && id_valid)
      ex_load_v = id_rd_we && (id_rd != '0);
  end

  // Shadow pipeline: always advances, only the EX entry depends on ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v   <= 1'b0;
      ex_rd  <= '0;
      mem_v  <= 1'b0;
      mem_rd <= '0;
      wb_v   <= 1'b0;
      wb_rd  <= '0;
    end else begin
      wb_v   <= mem_v;
      wb_rd  <= mem_rd;
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      ex_v   <= ex_load_v;
      ex_rd  <= ex_load_v ? id_rd : '0;
    end
  end

  // Source comparison against each stage. Stall/flush are deliberately absent here.
  always_comb begin
    hazard_ID_EXE  = id_valid && ex_v &&
                     ((id_rs1_re && (id_rs1 != '0) && (id_rs1 == ex_rd)) ||
                      (id_rs2_re && (id_rs2 != '0) && (id_rs2 == ex_rd)));
    hazard_EXE_MEM = id_valid && mem_v &&
                     ((id_rs1_re && (id_rs1 != '0) && (id_rs1 == mem_rd)) ||
                      (id_rs2_re && (id_rs2 != '0) && (id_rs2 == mem_rd)));
    hazard_MEM_WB  = id_valid && wb_v &&
                     ((id_rs1_re && (id_rs1 != '0) && (id_rs1 == wb_rd)) ||
                      (id_rs2_re && (id_rs2 != '0) && (id_rs2 == wb_rd)));
    any_hazard     = hazard_ID_EXE || hazard_EXE_MEM || hazard_MEM_WB;
    pend_cnt       = {1'b0, ex_v} + {1'b0, mem_v} + {1'b0, wb_v};
  end

  // Saturating count of cycles with any hazard asserted.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (any_hazard && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule
